param_sp_ram: RTL and testbench

PARAM_SP_RAM -- requirements
Module: param_sp_ram

---
 rtl/param_sp_ram.sv | 130 +++++++++++++
 tb/tb_param_sp_ram.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/param_sp_ram.sv
// rtl/param_sp_ram.sv - single-port RAM with byte-lane writes, init sweep and range checking
module param_sp_ram #(
  parameter int DATA_W = 8,
  parameter int BYTE_W = 8,
  parameter int ADDR_W = 6,
  parameter int DEPTH = 64,
  parameter int OUT_REG = 0,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req,
  input  logic                       we,
  input  logic [ADDR_W-1:0]          addr,
  input  logic [DATA_W-1:0]          data,
  input  logic [DATA_W/BYTE_W-1:0]   be,
  output logic                       ready,
  output logic [DATA_W-1:0]          q,
  output logic                       q_valid,
  output logic                       err,
  output logic                       init_done
);

  localparam int LANES = DATA_W / BYTE_W;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic {INIT, RUN} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;

  logic [DATA_W-1:0] mem [DEPTH];

  logic accept, in_range, wr_en, rd_en;
  logic              s1_valid, s1_err;
  logic [DATA_W-1:0] s1_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      INIT: begin
        if (cnt == LAST) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      RUN: begin
        state_nxt = RUN;
      end
      default: begin
        state_nxt = INIT;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign ready     = (state == RUN);
  assign init_done = (state == RUN);

  // The zero-extended compare stays correct when DEPTH == 2**ADDR_W, so err never fires then.
  assign in_range = ({1'b0, addr} < DEPTH_L);
  assign accept   = req && ready && !rst;
  assign wr_en    = accept && we && in_range;
  assign rd_en    = accept && !we;

  always_ff @(posedge clk) begin
    if (!rst && state == INIT) begin
      mem[cnt] <= INIT_VAL;
    end else if (wr_en) begin
      for (int i = 0; i < LANES; i++) begin
        if (be[i]) mem[addr][i*BYTE_W +: BYTE_W] <= data[i*BYTE_W +: BYTE_W];
      end
    end
  end

  // s1_data only updates on a read, so q holds its value between pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_err   <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= rd_en;
      s1_err   <= accept && !in_range;
      if (rd_en) s1_data <= in_range ? mem[addr] : '0;
    end
  end

  generate
    if (OUT_REG == 0) begin : g_direct
      assign q       = s1_data;
      assign q_valid = s1_valid;
      assign err     = s1_err;
    end else begin : g_outreg
      logic              s2_valid, s2_err;
      logic [DATA_W-1:0] s2_data;

      always_ff @(posedge clk) begin
        if (rst) begin
          s2_valid <= 1'b0;
          s2_err   <= 1'b0;
          s2_data  <= '0;
        end else begin
          s2_valid <= s1_valid;
          s2_err   <= s1_err;
          if (s1_valid) s2_data <= s1_data;
        end
      end

      assign q       = s2_data;
      assign q_valid = s2_valid;
      assign err     = s2_err;
    end
  endgenerate

endmodule

// File: tb/tb_param_sp_ram.sv
// tb/tb_param_sp_ram.sv - directed bench driving three RAM configurations from one stimulus stream
module tb_param_sp_ram;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req, we;
  logic [5:0]  addr;
  logic [15:0] data;
  logic [1:0]  be;

  // a: defaults; b: 16-bit words, DEPTH=48; c: 8-bit, OUT_REG=1
  logic [7:0]  q_a;
  logic        ready_a, q_valid_a, err_a, init_done_a;
  logic [15:0] q_b;
  logic        ready_b, q_valid_b, err_b, init_done_b;
  logic [7:0]  q_c;
  logic        ready_c, q_valid_c, err_c, init_done_c;

  param_sp_ram u_a (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .data(data[7:0]), .be(be[0:0]),
    .ready(ready_a), .q(q_a), .q_valid(q_valid_a), .err(err_a), .init_done(init_done_a)
  );

  param_sp_ram #(.DATA_W(16), .DEPTH(48)) u_b (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .data(data), .be(be),
    .ready(ready_b), .q(q_b), .q_valid(q_valid_b), .err(err_b), .init_done(init_done_b)
  );

  param_sp_ram #(.OUT_REG(1)) u_c (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .data(data[7:0]), .be(be[0:0]),
    .ready(ready_c), .q(q_c), .q_valid(q_valid_c), .err(err_c), .init_done(init_done_c)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic w, input logic [5:0] a,
                       input logic [15:0] d, input logic [1:0] b);
    req  = r;
    we   = w;
    addr = a;
    data = d;
    be   = b;
  endtask

  task automatic idle;
    drive(1'b0, 1'b0, 6'd0, 16'h0000, 2'b00);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    tick();
    check("rst_q_a", q_a, 0);
    check("rst_qv_a", q_valid_a, 0);
    check("rst_err_a", err_a, 0);
    check("rst_ready_a", ready_a, 0);
    check("rst_done_a", init_done_a, 0);
    check("rst_qv_c", q_valid_c, 0);
    rst = 1'b0;

    for (int i = 1; i <= 64; i++) begin
      tick();
      if (i == 47) check("sweep_ready_b_47", ready_b, 0);
      if (i == 48) check("sweep_ready_b_48", ready_b, 1);
      if (i == 63) begin
        check("sweep_ready_a_63", ready_a, 0);
        check("sweep_done_a_63", init_done_a, 0);
      end
      if (i == 64) begin
        check("sweep_ready_a_64", ready_a, 1);
        check("sweep_done_a_64", init_done_a, 1);
        check("sweep_ready_c_64", ready_c, 1);
      end
    end

    drive(1'b1, 1'b0, 6'd63, 16'h0000, 2'b00);
    tick();
    idle();
    check("rd63_qv_a", q_valid_a, 1);
    check("rd63_q_a", q_a, 8'h00);
    check("rd63_err_a", err_a, 0);
    check("rd63_qv_b", q_valid_b, 1);
    check("rd63_err_b", err_b, 1);
    check("rd63_q_b", q_b, 16'h0000);
    check("rd63_qv_c_early", q_valid_c, 0);
    tick();
    check("rd63_qv_a_drop", q_valid_a, 0);
    check("rd63_err_b_drop", err_b, 0);
    check("rd63_qv_c", q_valid_c, 1);
    check("rd63_q_c", q_c, 8'h00);
    check("rd63_err_c", err_c, 0);

    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 6'(i), 16'(i + 1), 2'b11);
      tick();
      check("wr_no_qv_a", q_valid_a, 0);
    end

    drive(1'b1, 1'b0, 6'd0, 16'h0000, 2'b00);
    tick();
    check("b2b0_q_a", q_a, 8'h01);
    check("b2b0_qv_a", q_valid_a, 1);
    check("b2b0_qv_c", q_valid_c, 0);
    drive(1'b1, 1'b0, 6'd1, 16'h0000, 2'b00);
    tick();
    check("b2b1_q_a", q_a, 8'h02);
    check("b2b1_qv_a", q_valid_a, 1);
    check("b2b1_q_c", q_c, 8'h01);
    check("b2b1_qv_c", q_valid_c, 1);
    drive(1'b1, 1'b0, 6'd2, 16'h0000, 2'b00);
    tick();
    check("b2b2_q_a", q_a, 8'h03);
    check("b2b2_qv_a", q_valid_a, 1);
    check("b2b2_q_b", q_b, 16'h0003);
    check("b2b2_q_c", q_c, 8'h02);
    idle();
    tick();
    check("hold_qv_a", q_valid_a, 0);
    check("hold_q_a", q_a, 8'h03);
    check("b2b3_q_c", q_c, 8'h03);
    check("b2b3_qv_c", q_valid_c, 1);
    tick();
    check("hold_qv_c", q_valid_c, 0);
    check("hold_q_c", q_c, 8'h03);

    drive(1'b1, 1'b1, 6'd1, 16'h0004, 2'b11);
    tick();
    drive(1'b1, 1'b0, 6'd1, 16'h0000, 2'b00);
    tick();
    idle();
    check("raw_q_a", q_a, 8'h04);
    check("raw_q_b", q_b, 16'h0004);

    drive(1'b1, 1'b1, 6'd5, 16'hABCD, 2'b11);
    tick();
    drive(1'b1, 1'b1, 6'd5, 16'h1200, 2'b10);
    tick();
    drive(1'b1, 1'b0, 6'd5, 16'h0000, 2'b00);
    tick();
    check("lane_q_b", q_b, 16'h12CD);
    check("lane_q_a", q_a, 8'hCD);
    drive(1'b1, 1'b1, 6'd5, 16'hFFFF, 2'b00);
    tick();
    drive(1'b1, 1'b0, 6'd5, 16'h0000, 2'b00);
    tick();
    idle();
    check("be0_q_b", q_b, 16'h12CD);
    check("be0_q_a", q_a, 8'hCD);
    check("be0_qv_b", q_valid_b, 1);

    drive(1'b1, 1'b1, 6'd50, 16'h00FF, 2'b11);
    tick();
    check("oor_wr_err_b", err_b, 1);
    check("oor_wr_qv_b", q_valid_b, 0);
    check("oor_wr_err_a", err_a, 0);
    drive(1'b1, 1'b0, 6'd50, 16'h0000, 2'b00);
    tick();
    check("oor_rd_q_b", q_b, 16'h0000);
    check("oor_rd_qv_b", q_valid_b, 1);
    check("oor_rd_err_b", err_b, 1);
    check("inr_rd_q_a", q_a, 8'hFF);
    drive(1'b1, 1'b0, 6'd0, 16'h0000, 2'b00);
    tick();
    idle();
    check("after_oor_q_b", q_b, 16'h0001);
    check("after_oor_err_b", err_b, 0);
    check("after_oor_qv_b", q_valid_b, 1);

    drive(1'b1, 1'b0, 6'd1, 16'h0000, 2'b00);
    tick();
    idle();
    rst = 1'b1;
    tick();
    check("flush_qv_c", q_valid_c, 0);
    check("flush_q_c", q_c, 8'h00);
    check("flush_qv_a", q_valid_a, 0);
    check("flush_q_a", q_a, 8'h00);
    check("flush_ready_a", ready_a, 0);
    rst = 1'b0;
    repeat (20) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("resweep_ready_a_0", ready_a, 0);

    for (int i = 1; i <= 64; i++) begin
      if (i >= 30 && i <= 60) drive(1'b1, 1'b1, 6'd0, 16'h0055, 2'b11);
      else idle();
      tick();
      if (i == 40) check("init_no_qv_a", q_valid_a, 0);
      if (i == 63) check("resweep_ready_a_63", ready_a, 0);
      if (i == 64) check("resweep_ready_a_64", ready_a, 1);
    end

    drive(1'b1, 1'b0, 6'd0, 16'h0000, 2'b00);
    tick();
    idle();
    check("init_drop_q_a", q_a, 8'h00);
    check("init_drop_qv_a", q_valid_a, 1);
    check("run_wr_q_b", q_b, 16'h0055);
    tick();
    check("init_drop_qv_c", q_valid_c, 1);
    check("init_drop_q_c", q_c, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
